fighter_renderer: RTL and testbench

// - Display-side consumer of the game_logic player outputs (state, position, sprite) for both players.
// - Generates 640x480@60 VGA timing from pixel_clk.
// - Snapshots the player registers once per frame, fetches sprite pixels from two sprite ROMs and drives registered RGB plus syncs.
// - Emits frame_tick so game_logic advances exactly one step per displayed frame.

---
 rtl/fighter_renderer.sv | 199 +++++++++++++++++++
 tb/tb_fighter_renderer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fighter_renderer.sv
// Two-player sprite renderer: VGA timing, per-frame player snapshot, dual sprite ROM fetch.
// Define MIRROR_P2_EN to draw player 2 horizontally flipped.
module fighter_renderer #(
  parameter int unsigned POSITION_DEPTH     = 10,
  parameter int unsigned SPRITE_INDEX_DEPTH = 4,
  parameter int unsigned STATE_DEPTH        = 4,
  parameter int unsigned SPRITE_W           = 32,
  parameter int unsigned SPRITE_H           = 64,
  parameter int unsigned SPRITE_TOP         = 336,
  parameter logic [7:0]  TRANSPARENT        = 8'h00,
  parameter logic [7:0]  BG_COLOR           = 8'h25,
  parameter int unsigned H_ACTIVE           = 640,
  parameter int unsigned H_FP               = 16,
  parameter int unsigned H_SYNC             = 96,
  parameter int unsigned H_BP               = 48,
  parameter int unsigned V_ACTIVE           = 480,
  parameter int unsigned V_FP               = 10,
  parameter int unsigned V_SYNC             = 2,
  parameter int unsigned V_BP               = 33
) (
  input  logic                                                   i_pixel_clk,
  input  logic                                                   i_rst_n,
  input  logic [POSITION_DEPTH-1:0]                              i_p1_position,
  input  logic [POSITION_DEPTH-1:0]                              i_p2_position,
  input  logic [SPRITE_INDEX_DEPTH-1:0]                          i_p1_sprite,
  input  logic [SPRITE_INDEX_DEPTH-1:0]                          i_p2_sprite,
  input  logic [STATE_DEPTH-1:0]                                 i_p1_state,
  input  logic [STATE_DEPTH-1:0]                                 i_p2_state,
  output logic [SPRITE_INDEX_DEPTH+$clog2(SPRITE_W*SPRITE_H)-1:0] o_p1_rom_addr,
  output logic [SPRITE_INDEX_DEPTH+$clog2(SPRITE_W*SPRITE_H)-1:0] o_p2_rom_addr,
  input  logic [7:0]                                             i_p1_rom_data,
  input  logic [7:0]                                             i_p2_rom_data,
  output logic [7:0]                                             o_rgb,
  output logic                                                   o_hsync,
  output logic                                                   o_vsync,
  output logic                                                   o_de,
  output logic                                                   o_frame_tick
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW     = $clog2(HTotal);
  localparam int unsigned VW     = $clog2(VTotal);
  localparam int unsigned XW     = POSITION_DEPTH + 1;
  localparam int unsigned RowW   = $clog2(SPRITE_H);
  localparam int unsigned ColW   = $clog2(SPRITE_W);

  localparam logic [HW-1:0] HLast     = HW'(HTotal - 1);
  localparam logic [HW-1:0] HActive   = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HSyncBeg  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HSyncEnd  = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VLast     = VW'(VTotal - 1);
  localparam logic [VW-1:0] VActive   = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VSyncBeg  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VSyncEnd  = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] VSprBeg   = VW'(SPRITE_TOP);
  localparam logic [VW-1:0] VSprEnd   = VW'(SPRITE_TOP + SPRITE_H);
  localparam logic [XW-1:0] SprWidth  = XW'(SPRITE_W);
  localparam logic [RowW-1:0] SprTopLo = RowW'(SPRITE_TOP);

  logic [HW-1:0] r_hcnt;
  logic [VW-1:0] r_vcnt;

  logic [POSITION_DEPTH-1:0]     r_p1_pos, r_p2_pos;
  logic [SPRITE_INDEX_DEPTH-1:0] r_p1_spr, r_p2_spr;
  logic [STATE_DEPTH-1:0]        r_p1_state, r_p2_state;
  logic                          r_snap_valid;

  logic r_p1_hit1, r_p2_hit1, r_de1, r_hs1, r_vs1;
  logic [7:0] r_rgb;
  logic r_de2, r_hs2, r_vs2, r_frame_tick;

  logic            w_snap;
  logic            w_de0, w_hs0, w_vs0, w_vin;
  logic [XW-1:0]   w_hx, w_x1, w_x2, w_x1_end, w_x2_end;
  logic            w_p1_hit, w_p2_hit;
  logic [RowW-1:0] w_row;
  logic [ColW-1:0] w_col1, w_col2_raw, w_col2;
  logic [7:0]      w_rgb_next;
  logic            w_unused_state;

  // Raster counters
  always_ff @(posedge i_pixel_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (r_hcnt == HLast) begin
      r_hcnt <= '0;
      r_vcnt <= (r_vcnt == VLast) ? '0 : r_vcnt + 1'b1;
    end else begin
      r_hcnt <= r_hcnt + 1'b1;
    end
  end

  assign w_snap = (r_hcnt == '0) && (r_vcnt == VActive);

  always_ff @(posedge i_pixel_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_p1_pos     <= '0;
      r_p2_pos     <= '0;
      r_p1_spr     <= '0;
      r_p2_spr     <= '0;
      r_p1_state   <= '0;
      r_p2_state   <= '0;
      r_snap_valid <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_snap;
      if (w_snap) begin
        r_p1_pos     <= i_p1_position;
        r_p2_pos     <= i_p2_position;
        r_p1_spr     <= i_p1_sprite;
        r_p2_spr     <= i_p2_sprite;
        r_p1_state   <= i_p1_state;
        r_p2_state   <= i_p2_state;
        r_snap_valid <= 1'b1;
      end
    end
  end

  // State is latched for game-side consumers only; nothing here decodes it.
  assign w_unused_state = ^{r_p1_state, r_p2_state};

  assign w_de0 = (r_hcnt < HActive) && (r_vcnt < VActive);
  assign w_hs0 = !((r_hcnt >= HSyncBeg) && (r_hcnt < HSyncEnd));
  assign w_vs0 = !((r_vcnt >= VSyncBeg) && (r_vcnt < VSyncEnd));
  assign w_vin = (r_vcnt >= VSprBeg) && (r_vcnt < VSprEnd);

  // One extra bit keeps x+SPRITE_W from wrapping near the top of the position range.
  assign w_hx     = XW'(r_hcnt);
  assign w_x1     = {1'b0, r_p1_pos};
  assign w_x2     = {1'b0, r_p2_pos};
  assign w_x1_end = w_x1 + SprWidth;
  assign w_x2_end = w_x2 + SprWidth;

  assign w_p1_hit = w_vin && (w_hx >= w_x1) && (w_hx < w_x1_end) && r_snap_valid;
  assign w_p2_hit = w_vin && (w_hx >= w_x2) && (w_hx < w_x2_end) && r_snap_valid;

  assign w_row      = RowW'(r_vcnt) - SprTopLo;
  assign w_col1     = ColW'(r_hcnt) - ColW'(r_p1_pos);
  assign w_col2_raw = ColW'(r_hcnt) - ColW'(r_p2_pos);
`ifdef MIRROR_P2_EN
  assign w_col2 = ~w_col2_raw;
`else
  assign w_col2 = w_col2_raw;
`endif

  assign o_p1_rom_addr = {r_p1_spr, w_row, w_col1};
  assign o_p2_rom_addr = {r_p2_spr, w_row, w_col2};

  // Stage 1: ROM data lands this cycle; align control with it.
  always_ff @(posedge i_pixel_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_p1_hit1 <= 1'b0;
      r_p2_hit1 <= 1'b0;
      r_de1     <= 1'b0;
      r_hs1     <= 1'b1;
      r_vs1     <= 1'b1;
    end else begin
      r_p1_hit1 <= w_p1_hit;
      r_p2_hit1 <= w_p2_hit;
      r_de1     <= w_de0;
      r_hs1     <= w_hs0;
      r_vs1     <= w_vs0;
    end
  end

  always_comb begin
    w_rgb_next = BG_COLOR;
    if (!r_de1) begin
      w_rgb_next = 8'h00;
    end else if (r_p1_hit1 && (i_p1_rom_data != TRANSPARENT)) begin
      w_rgb_next = i_p1_rom_data;
    end else if (r_p2_hit1 && (i_p2_rom_data != TRANSPARENT)) begin
      w_rgb_next = i_p2_rom_data;
    end
  end

  always_ff @(posedge i_pixel_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rgb <= 8'h00;
      r_de2 <= 1'b0;
      r_hs2 <= 1'b1;
      r_vs2 <= 1'b1;
    end else begin
      r_rgb <= w_rgb_next;
      r_de2 <= r_de1;
      r_hs2 <= r_hs1;
      r_vs2 <= r_vs1;
    end
  end

  assign o_rgb        = r_rgb;
  assign o_de         = r_de2;
  assign o_hsync      = r_hs2;
  assign o_vsync      = r_vs2;
  assign o_frame_tick = r_frame_tick;

endmodule

// File: tb/tb_fighter_renderer.sv
// Directed bench for fighter_renderer on a shrunken raster (80x55) with 8x4 sprites.
`timescale 1ns/1ps
module tb_fighter_renderer;

  localparam int HA = 64, HFP = 4, HS = 8, HBP = 4, HT = HA + HFP + HS + HBP;
  localparam int VA = 48, VFP = 2, VS = 2, VBP = 3, VT = VA + VFP + VS + VBP;
  localparam int FT = HT * VT;
  localparam int SNAP = VA * HT;
  localparam logic [7:0] BG = 8'h25;

`ifdef MIRROR_P2_EN
  localparam logic [7:0] EC2A = 8'h52, EC3A = 8'h4E, EC4A = 8'h67, EC4B = 8'h64;
  localparam logic [8:0] EA2 = 9'h027;
`else
  localparam logic [7:0] EC2A = 8'h55, EC3A = 8'h49, EC4A = 8'h60, EC4B = 8'h63;
  localparam logic [8:0] EA2 = 9'h020;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] p1_x, p2_x;
  logic [3:0] p1_s, p2_s, p1_st, p2_st;
  logic [8:0] a1, a2;
  logic [7:0] rom1, rom2, rgb;
  logic       hsync, vsync, de, ftick;
  logic       m1, m2;

  always #5 clk = ~clk;

  fighter_renderer #(
    .SPRITE_W(8), .SPRITE_H(4), .SPRITE_TOP(20),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
  ) dut (
    .i_pixel_clk(clk), .i_rst_n(rst_n),
    .i_p1_position(p1_x), .i_p2_position(p2_x),
    .i_p1_sprite(p1_s), .i_p2_sprite(p2_s),
    .i_p1_state(p1_st), .i_p2_state(p2_st),
    .o_p1_rom_addr(a1), .o_p2_rom_addr(a2),
    .i_p1_rom_data(rom1), .i_p2_rom_data(rom2),
    .o_rgb(rgb), .o_hsync(hsync), .o_vsync(vsync), .o_de(de), .o_frame_tick(ftick)
  );

  // Synchronous ROMs: p1 colour {1,addr[6:0]}, p2 colour {01,addr[5:0]}; mode 0 = transparent.
  always @(posedge clk) begin
    rom1 <= m1 ? {1'b1, a1[6:0]} : 8'h00;
    rom2 <= m2 ? {2'b01, a2[5:0]} : 8'h00;
  end

  // Cycle position within the frame, mirrors the raster independently of the DUT.
  int lin;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) lin <= 0;
    else        lin <= (lin == FT - 1) ? 0 : lin + 1;
  end

  int ft_cnt = 0;
  always @(posedge clk) begin
    if (ftick) ft_cnt <= ft_cnt + 1;
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic int pos(input int h, input int v, input int lat);
    return (v * HT + h + lat) % FT;
  endfunction

  task automatic wait_lin(input int target);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (lin != target && n < 2 * FT);
    if (lin != target) begin
      total++;
      bad++;
      $display("FAIL wait_lin: reached %0d want %0d", lin, target);
    end
  endtask

  typedef struct {
    logic [9:0] x1; logic [3:0] s1; logic [9:0] x2; logic [3:0] s2; logic m1; logic m2;
  } cfg_t;
  typedef struct { int cfg; int h; int v; logic [7:0] rgb; } vec_t;

  cfg_t cfgs[5];
  vec_t vecs[17];

  task automatic apply_cfg(input cfg_t c);
    p1_x = c.x1; p1_s = c.s1; p2_x = c.x2; p2_s = c.s2; m1 = c.m1; m2 = c.m2;
  endtask

  initial begin
    int cur;
    int c0;
    cfgs[0] = '{10'd10,  4'd3, 10'd700, 4'd0, 1'b1, 1'b1};  // p1 alone
    cfgs[1] = '{10'd20,  4'd1, 10'd24,  4'd2, 1'b1, 1'b1};  // overlap
    cfgs[2] = '{10'd20,  4'd1, 10'd24,  4'd2, 1'b0, 1'b1};  // overlap, p1 transparent
    cfgs[3] = '{10'd700, 4'd0, 10'd60,  4'd1, 1'b1, 1'b1};  // p2 clipped at right edge
    cfgs[4] = '{10'd700, 4'd0, 10'd70,  4'd1, 1'b1, 1'b1};  // p2 off screen
    vecs[0]  = '{0, 12, 19, BG};
    vecs[1]  = '{0, 9,  20, BG};
    vecs[2]  = '{0, 10, 20, 8'hE0};
    vecs[3]  = '{0, 18, 20, BG};
    vecs[4]  = '{0, 70, 21, 8'h00};
    vecs[5]  = '{0, 17, 23, 8'hFF};
    vecs[6]  = '{0, 12, 24, BG};
    vecs[7]  = '{1, 25, 21, 8'hAD};
    vecs[8]  = '{1, 29, 22, EC2A};
    vecs[9]  = '{2, 22, 21, BG};
    vecs[10] = '{2, 25, 21, EC3A};
    vecs[11] = '{3, 59, 20, BG};
    vecs[12] = '{3, 60, 20, EC4A};
    vecs[13] = '{3, 63, 20, EC4B};
    vecs[14] = '{3, 65, 20, 8'h00};
    vecs[15] = '{4, 6,  20, BG};
    vecs[16] = '{4, 63, 20, BG};

    p1_x = 10'd0; p1_s = 4'd0; p2_x = 10'd700; p2_s = 4'd0;
    p1_st = 4'd5; p2_st = 4'd9; m1 = 1'b1; m2 = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_rgb", rgb, 8'h00);
    chk("rst_hsync", hsync, 1'b1);
    chk("rst_vsync", vsync, 1'b1);
    chk("rst_de", de, 1'b0);
    chk("rst_ftick", ftick, 1'b0);
    rst_n = 1'b1;

    // No snapshot yet: p1 at x=0 must stay hidden.
    wait_lin(pos(3, 21, 2));
    chk("pre_rgb", rgb, BG);
    chk("pre_de", de, 1'b1);
    chk("pre_hsync", hsync, 1'b1);
    wait_lin(pos(70, 21, 2));
    chk("blank_rgb", rgb, 8'h00);
    chk("blank_de", de, 1'b0);
    chk("blank_hsync", hsync, 1'b0);

    wait_lin(SNAP);
    chk("ftick_before", ftick, 1'b0);
    wait_lin(SNAP + 1);
    chk("ftick_pulse", ftick, 1'b1);
    wait_lin(SNAP + 2);
    chk("ftick_after", ftick, 1'b0);

    wait_lin(HT * (VA + VFP) + 1);
    chk("vsync_pre", vsync, 1'b1);
    wait_lin(HT * (VA + VFP) + 2);
    chk("vsync_first_low", vsync, 1'b0);
    wait_lin(HT * (VA + VFP + VS) + 1);
    chk("vsync_last_low", vsync, 1'b0);
    wait_lin(HT * (VA + VFP + VS) + 2);
    chk("vsync_release", vsync, 1'b1);

    cur = -1;
    for (int i = 0; i < 17; i++) begin
      if (vecs[i].cfg != cur) begin
        apply_cfg(cfgs[vecs[i].cfg]);
        wait_lin(SNAP + 1);
        cur = vecs[i].cfg;
      end
      wait_lin(pos(vecs[i].h, vecs[i].v, 2));
      chk($sformatf("vec%0d_rgb", i), rgb, vecs[i].rgb);
    end

    // Addressing and mid-frame input change.
    apply_cfg('{10'd10, 4'd3, 10'd40, 4'd1, 1'b1, 1'b1});
    wait_lin(SNAP + 1);
    c0 = ft_cnt;
    wait_lin(pos(0, 10, 0));
    p1_x = 10'd30;
    wait_lin(pos(10, 20, 0));
    chk("addr_p1", a1, 9'h060);
    wait_lin(pos(10, 20, 2));
    chk("mid_old_pos", rgb, 8'hE0);
    wait_lin(pos(30, 20, 2));
    chk("mid_new_pos", rgb, BG);
    wait_lin(pos(40, 20, 0));
    chk("addr_p2", a2, EA2);
    wait_lin(SNAP + 1);
    chk("ftick_per_frame", ft_cnt - c0, 1);
    wait_lin(pos(10, 20, 2));
    chk("next_old_pos", rgb, BG);
    wait_lin(pos(30, 20, 2));
    chk("next_new_pos", rgb, 8'hE0);

    // Asynchronous reset in the middle of a sprite.
    wait_lin(pos(31, 21, 2));
    chk("pre_reset_rgb", rgb, 8'hE9);
    #1 rst_n = 1'b0;
    #1;
    chk("mrst_rgb", rgb, 8'h00);
    chk("mrst_de", de, 1'b0);
    chk("mrst_hsync", hsync, 1'b1);
    chk("mrst_vsync", vsync, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_lin(pos(31, 21, 2));
    chk("post_reset_hidden", rgb, BG);
    wait_lin(HT * (VA + VFP) + 2);
    chk("post_reset_vsync", vsync, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
